// File: rtl/alt_ddrx_odt_gen_mr_pkg.sv
// Shared constants and helpers for the multi-rank ODT generator.
package alt_ddrx_odt_gen_mr_pkg;

  // ODT turn-on lead (mem clocks) ahead of write data.
  localparam int unsigned ODT_TAOND     = 2;
  // Extra mem clocks added to the burst to form the ODT window.
  localparam int unsigned ODT_WIN_EXTRA = 2;

  // Mem clocks added by the optional PHY output register stage.
  function automatic int unsigned odt_regd_offset(input int unsigned regd,
                                                  input int unsigned ratio);
    if (regd == 0) return 0;
    return (ratio == 4) ? 2 : 1;
  endfunction

  // LSB of the CS-bit map field that belongs to target rank 'rank'.
  function automatic int unsigned odt_map_lsb(input int unsigned rank,
                                              input int unsigned cs);
    return rank * cs;
  endfunction

endpackage

// File: rtl/alt_ddrx_odt_rank_timer.sv
// Per-rank ODT window timer: max-merging remaining-mem-clock counter plus
// a combinational start term so a window can assert in its start cycle.
module alt_ddrx_odt_rank_timer
  import alt_ddrx_odt_gen_mr_pkg::*;
#(
  parameter int unsigned DWIDTH_RATIO = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             ctl_clk,
  input  logic             ctl_reset_n,
  input  logic             start,
  input  logic             start_phase,
  input  logic [CNT_W-1:0] length,
  output logic             odt_l,
  output logic             odt_h
);

  localparam int unsigned      PHASES = DWIDTH_RATIO / 2;
  localparam logic [CNT_W-1:0] STEP   = CNT_W'(PHASES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_rem;
  logic [CNT_W-1:0] w_new;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_phase;

  // Remaining mem clocks after this cycle; a start merges by taking the max.
  always_comb begin
    w_phase   = (PHASES > 1) ? start_phase : 1'b0;
    w_rem     = (r_cnt > STEP) ? (r_cnt - STEP) : '0;
    w_new     = length - (STEP - CNT_W'(w_phase));
    w_cnt_nxt = w_rem;
    if (start && (w_new > w_rem)) w_cnt_nxt = w_new;
  end

  // Counter register; r_cnt counts mem clocks from phase 0 of the current cycle.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) r_cnt <= '0;
    else              r_cnt <= w_cnt_nxt;
  end

  // Output = start term OR hold term; phase 1 needs two remaining mem clocks.
  always_comb begin
    odt_l = (start && !w_phase) || (r_cnt != '0);
    odt_h = odt_l;
    if (PHASES > 1) odt_h = start || (r_cnt > CNT_W'(1));
  end

endmodule

// File: rtl/alt_ddrx_odt_gen_mr.sv
// Multi-rank, multi-rate ODT generator: latency register, command delay
// pipe with write/read taps, map decode and one window timer per rank.
module alt_ddrx_odt_gen_mr
  import alt_ddrx_odt_gen_mr_pkg::*;
#(
  parameter int unsigned DWIDTH_RATIO       = 2,
  parameter int unsigned MEM_IF_CS_WIDTH    = 2,
  parameter int unsigned MEMORY_BURSTLENGTH = 8,
  parameter int unsigned ADD_LAT_BUS_WIDTH  = 3,
  parameter int unsigned TCL_BUS_WIDTH      = 4,
  parameter int unsigned CTL_OUTPUT_REGD    = 0
) (
  input  logic                                       ctl_clk,
  input  logic                                       ctl_reset_n,
  input  logic [TCL_BUS_WIDTH-1:0]                   mem_tcl,
  input  logic [ADD_LAT_BUS_WIDTH-1:0]               mem_add_lat,
  input  logic [MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH-1:0] cfg_write_odt_chip,
  input  logic [MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH-1:0] cfg_read_odt_chip,
  input  logic                                       do_write,
  input  logic                                       do_read,
  input  logic [MEM_IF_CS_WIDTH-1:0]                 to_chip,
  output logic [MEM_IF_CS_WIDTH-1:0]                 int_odt_l,
  output logic [MEM_IF_CS_WIDTH-1:0]                 int_odt_h
);

  localparam int unsigned CS      = MEM_IF_CS_WIDTH;
  localparam int unsigned TW      = TCL_BUS_WIDTH + 1;
  localparam int unsigned IDX_W   = TCL_BUS_WIDTH;
  localparam int unsigned DEPTH   = 2 ** TCL_BUS_WIDTH;
  localparam int unsigned HALF    = (DWIDTH_RATIO == 4) ? 1 : 0;
  localparam int unsigned REGD    = odt_regd_offset(CTL_OUTPUT_REGD, DWIDTH_RATIO);
  localparam int unsigned WIN_LEN = MEMORY_BURSTLENGTH / 2 + ODT_WIN_EXTRA;
  localparam int unsigned CNT_W   = $clog2(WIN_LEN + 2) + 1;

  logic [TW-1:0]    r_int_tcwl;
  logic [TW-1:0]    w_tcwl_sum;
  logic [TW-1:0]    w_s_wr, w_s_rd, w_d_wr, w_d_rd;
  logic             w_ph_wr, w_ph_rd;
  logic [IDX_W-1:0] w_idx_wr, w_idx_rd;
  logic [CS-1:0]    w_tgt_low, w_wr_now, w_rd_now;
  logic [CS-1:0]    w_wr_tap, w_rd_tap;
  logic [CS-1:0]    w_wr_stage [DEPTH];
  logic [CS-1:0]    w_rd_stage [DEPTH];
  logic [CS-1:0]    w_wr_col   [CS];
  logic [CS-1:0]    w_rd_col   [CS];

  // Unsigned sum of the latency terms, wide enough not to overflow.
  always_comb begin
    w_tcwl_sum = TW'(mem_tcl) + TW'(mem_add_lat) + TW'(REGD);
  end

  // Registered write latency, floored at zero.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n)           r_int_tcwl <= '0;
    else if (w_tcwl_sum != '0)  r_int_tcwl <= w_tcwl_sum - TW'(1);
    else                        r_int_tcwl <= '0;
  end

  // Start offsets in mem clocks, split into ctl-cycle delay and start phase.
  always_comb begin
    w_s_wr   = (r_int_tcwl >= TW'(ODT_TAOND))     ? (r_int_tcwl - TW'(ODT_TAOND))     : '0;
    w_s_rd   = (r_int_tcwl >= TW'(ODT_TAOND - 1)) ? (r_int_tcwl - TW'(ODT_TAOND - 1)) : '0;
    w_d_wr   = w_s_wr >> HALF;
    w_d_rd   = w_s_rd >> HALF;
    w_ph_wr  = (HALF == 1) ? w_s_wr[0] : 1'b0;
    w_ph_rd  = (HALF == 1) ? w_s_rd[0] : 1'b0;
    w_idx_wr = (w_d_wr > TW'(DEPTH - 1)) ? IDX_W'(DEPTH - 1) : IDX_W'(w_d_wr);
    w_idx_rd = (w_d_rd > TW'(DEPTH - 1)) ? IDX_W'(DEPTH - 1) : IDX_W'(w_d_rd);
  end

  // Command entry: lowest target rank, write wins over a simultaneous read.
  always_comb begin
    w_tgt_low = to_chip & (~to_chip + CS'(1));
    w_wr_now  = (do_write && ctl_reset_n) ? w_tgt_low : '0;
    w_rd_now  = (do_read && !do_write && ctl_reset_n) ? w_tgt_low : '0;
  end

  assign w_wr_stage[0] = w_wr_now;
  assign w_rd_stage[0] = w_rd_now;

  for (genvar k = 1; k < DEPTH; k++) begin : g_pipe
    logic [CS-1:0] r_wr;
    logic [CS-1:0] r_rd;

    // One ctl cycle of command delay per stage.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
      if (!ctl_reset_n) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        r_wr <= w_wr_stage[k-1];
        r_rd <= w_rd_stage[k-1];
      end
    end

    assign w_wr_stage[k] = r_wr;
    assign w_rd_stage[k] = r_rd;
  end

  // Tap the stage whose command starts its ODT window this cycle.
  always_comb begin
    w_wr_tap = w_wr_stage[w_idx_wr];
    w_rd_tap = w_rd_stage[w_idx_rd];
  end

  // Transpose the maps: column r lists which targets make rank r drive ODT.
  for (genvar r = 0; r < CS; r++) begin : g_col
    for (genvar i = 0; i < CS; i++) begin : g_bit
      assign w_wr_col[r][i] = cfg_write_odt_chip[odt_map_lsb(i, CS) + r];
      assign w_rd_col[r][i] = cfg_read_odt_chip[odt_map_lsb(i, CS) + r];
    end
  end

  for (genvar r = 0; r < CS; r++) begin : g_rank
    logic             w_start_wr, w_start_rd, w_start, w_phase;
    logic [CNT_W-1:0] w_len;

    // Merge coincident write/read starts into one window covering both.
    always_comb begin
      w_start_wr = |(w_wr_tap & w_wr_col[r]);
      w_start_rd = |(w_rd_tap & w_rd_col[r]);
      w_start    = w_start_wr || w_start_rd;
      w_phase    = w_start_wr ? w_ph_wr : w_ph_rd;
      w_len      = CNT_W'(WIN_LEN);
      if (w_start_wr && w_start_rd) begin
        w_phase = w_ph_wr & w_ph_rd;
        if (w_ph_wr != w_ph_rd) w_len = CNT_W'(WIN_LEN + 1);
      end
    end

    alt_ddrx_odt_rank_timer #(
      .DWIDTH_RATIO (DWIDTH_RATIO),
      .CNT_W        (CNT_W)
    ) u_timer (
      .ctl_clk     (ctl_clk),
      .ctl_reset_n (ctl_reset_n),
      .start       (w_start),
      .start_phase (w_phase),
      .length      (w_len),
      .odt_l       (int_odt_l[r]),
      .odt_h       (int_odt_h[r])
    );
  end

endmodule

// File: doc/alt_ddrx_odt_gen_mr.md
# alt_ddrx_odt_gen_mr

Multi-rank, multi-rate ODT generator for the DDRx controller. It replaces the single-rank DDR2 ODT block on the controller-to-PHY command path. Each read or write command is mapped through per-rank configuration maps to a set of ODT-driving ranks, and a timed window is generated per rank. Burst length, full/half rate and output registering are parameters.

## Interface
- DWIDTH_RATIO, 2, 2 = full rate (1 mem clock per ctl cycle); 4 = half rate (2 mem clocks per ctl cycle)
- MEM_IF_CS_WIDTH, 2, number of ranks (1–4)
- MEMORY_BURSTLENGTH, 8, 4 or 8
- ADD_LAT_BUS_WIDTH, 3, width of mem_add_lat
- TCL_BUS_WIDTH, 4, width of mem_tcl; delay pipe depth = 2**TCL_BUS_WIDTH ctl cycles
- CTL_OUTPUT_REGD, 0, 1 adds the PHY output register stage: +1 mem clock (full rate) or +2 (half rate)

Ports:
- ctl_clk  in  1  controller clock
- ctl_reset_n  in  1  asynchronous, active-low reset
- mem_tcl  in  TCL_BUS_WIDTH  CAS latency (quasi-static)
- mem_add_lat  in  ADD_LAT_BUS_WIDTH  additive latency (quasi-static)
- cfg_write_odt_chip  in  CS*CS  bits [i*CS +: CS] = ranks driving ODT for a write to rank i
- cfg_read_odt_chip  in  CS*CS  same format, for reads
- do_write  in  1  write command issued this cycle, in phase 0
- do_read  in  1  read command issued this cycle, in phase 0
- to_chip  in  CS  target rank, one-hot
- int_odt_l  out  CS  per-rank ODT, phase 0 (first mem clock of the ctl cycle)
- int_odt_h  out  CS  per-rank ODT, phase 1; equals int_odt_l when DWIDTH_RATIO=2

## Operation
- Latency:
  - int_tcwl = mem_tcl + mem_add_lat + regd − 1, registered; regd is 0, 1 or 2 per CTL_OUTPUT_REGD and rate.
  - Compute in TCL_BUS_WIDTH+1 bits, unsigned, with no overflow.
- Start offset S, in mem clocks after the command's phase 0:
  - Write: S = int_tcwl − 2.
  - Read: S = int_tcwl − 1.
  - S is clamped at 0.
- Window length L = MEMORY_BURSTLENGTH/2 + 2 mem clocks, for both reads and writes.
- Rank decode:
  - Target rank = lowest set bit of to_chip.
  - If to_chip = 0, the command is ignored.
  - The ODT rank set is the map entry for the target rank.
- Command entry:
  - {wr, rd, target} enters a shift pipe every cycle (zero when idle).
  - The pipe tap selects the command that reaches its start cycle now.
- Start position:
  - Start ctl cycle = S / (DWIDTH_RATIO/2), integer division.
  - In half rate, an odd S starts in phase 1.
- Per-rank timer:
  - Each ODT rank holds a remaining-mem-clock counter.
  - A new start sets the counter to max(remaining, L), so overlapping windows merge into their union.
  - Each phase decrements the counter by 1.
- Output composition:
  - Each output = combinational start term OR registered hold term.
  - With S = 0, ODT asserts in the command's own cycle.
- Simultaneous do_write and do_read: the write wins and the read is dropped.
- Reset, including mid-window: all outputs, timers, the pipe and int_tcwl go to 0 immediately. After release, no window resumes.
- mem_tcl, mem_add_lat and the maps must be stable for ≥2 cycles before a command. Changing them with commands in flight is unsupported.

## Timing
- Reset values: int_odt_l = 0, int_odt_h = 0.
- First ODT cycle = command cycle + floor(S / (DWIDTH_RATIO/2)).
- Full rate: ODT is high for exactly L consecutive cycles.
- Half rate:
  - S even: L/2 cycles with l = h = 1.
  - S odd: one cycle with h only, then L/2 − 1 cycles with l = h = 1, then one cycle with l only.
- Maximum supported S is 2**TCL_BUS_WIDTH − 1 ctl cycles of delay.

## Structure
- Shared package/include holds:
  - constants ODT_TAOND = 2 and ODT_WIN_EXTRA = 2;
  - the regd offset function;
  - the map-slice helper (rank i → CS-bit field).
- Sub-module alt_ddrx_odt_rank_timer (one per rank, generate loop):
  - inputs: start, start_phase, length;
  - outputs: odt_l, odt_h.
  - It contains the max-merge counter and the combinational start term.
- The top level contains the latency register, command pipe, tap mux and map decode.

## Test plan
- Full rate, BL4, CS=1, tcl=4, al=0, regd=0 (int_tcwl=3, S=1, L=4): write to rank0 at cycle 0 → int_odt_l[0] high at cycles 1–4, low at cycle 5.
- Half rate, BL8, tcl=5 (int_tcwl=4, S=2, L=6): write at cycle 0 → l = h = 1 at cycles 1–3; both 0 at cycle 4.
- Half rate, BL8, tcl=6 (int_tcwl=5, S=3): write at cycle 0 → cycle 1 h only; cycles 2–3 l = h; cycle 4 l only; cycle 5 both 0.
- Full rate, CS=2, BL4, tcl=4, cfg_read_odt_chip[1:0] = 2'b10: read to rank0 at cycle 0 → int_odt_l[1] high at cycles 2–5; int_odt_l[0] stays 0 throughout.
- Full rate, BL4, tcl=4: writes at cycles 0 and 2 → one continuous window at cycles 1–6. Simultaneous do_write/do_read → write timing only.
- Assert reset at cycle 2 during the window → all outputs 0 in the same cycle. After release they stay 0 with no residual window.
